// File: rtl/ctrl_reg_pkg.sv
// Shared definitions for the control register bank: channel FSM encoding
// and the bit positions of the fields in each 32-bit channel word.
package ctrl_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } chan_state_e;

  localparam int GO      = 0;
  localparam int MODE    = 1;
  localparam int ABORT   = 2;
  localparam int IE      = 3;
  localparam int BUSY    = 4;
  localparam int DONE    = 5;
  localparam int CNT_LSB = 8;

endpackage

// File: rtl/ctrl_chan.sv
// One channel of the control register bank: IDLE/BUSY/DONE sequencer with a
// saturating event counter, sticky done flag and start pulse.
// Optional feature: CTRL_REG_BANK_IRQ_EN makes the ie bit writable.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no operation; mode/ie writable, go starts an operation
// BUSY    | operation running; counts hw_inc, ends on hw_done or abort
// DONE    | operation finished by hardware; go restarts it
module ctrl_chan
  import ctrl_reg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        go_bit,
  input  logic        mode_bit,
  input  logic        abort_bit,
  input  logic        ie_bit,
  input  logic        clr_bit,
  input  logic        hw_inc,
  input  logic        hw_done,
  output logic [31:0] word,
  output logic        start_pulse,
  output logic        irq_req
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             ie_q, ie_d;
  logic             done_q, done_d;
  logic             start_q, start_d;

`ifndef CTRL_REG_BANK_IRQ_EN
  logic unused_ie_bit;
  assign unused_ie_bit = ie_bit;
`endif

  // Next-state: hardware events take priority over software go/abort while BUSY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    ie_d    = ie_q;
    done_d  = done_q;
    start_d = 1'b0;
    if (we && clr_bit) done_d = 1'b0;
    case (state_q)
      ST_BUSY: begin
        if (hw_inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        if (hw_done) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (we && abort_bit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (we) begin
          mode_d = mode_bit;
`ifdef CTRL_REG_BANK_IRQ_EN
          ie_d   = ie_bit;
`else
          ie_d   = 1'b0;
`endif
        end
        if (we && go_bit) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          done_d  = 1'b0;
          start_d = 1'b1;
        end
      end
    endcase
  end

  // Channel state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  // Assemble the software-visible word; go reads back as busy.
  always_comb begin
    word                    = '0;
    word[GO]                = (state_q == ST_BUSY);
    word[MODE]              = mode_q;
    word[IE]                = ie_q;
    word[BUSY]              = (state_q == ST_BUSY);
    word[DONE]              = done_q;
    word[CNT_LSB +: CNT_W]  = cnt_q;
  end

  assign start_pulse = start_q;
  assign irq_req     = done_q & ie_q;

endmodule

// File: rtl/ctrl_reg_bank.sv
// Control register bank: N_CH channel sequencers behind a simple software
// port, with address decode, combinational read mux and interrupt.
// Optional feature: CTRL_REG_BANK_IRQ_EN enables the registered irq output.
module ctrl_reg_bank
  import ctrl_reg_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_we,
  input  logic [AW-1:0]     sw_addr,
  input  logic [31:0]       sw_wdata,
  output logic [31:0]       sw_rdata,
  input  logic [N_CH-1:0]   hw_inc,
  input  logic [N_CH-1:0]   hw_done,
  output logic [N_CH-1:0]   start_pulse,
  output logic [32*N_CH-1:0] ctrl_out,
  output logic              irq
);

  logic [31:0]     chan_word [N_CH];
  logic [N_CH-1:0] chan_we;
  logic [N_CH-1:0] chan_irq;

  logic unused_wdata;
  assign unused_wdata = ^{sw_wdata[31:6], sw_wdata[BUSY]};

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign chan_we[i] = sw_we && (sw_addr == AW'(i));

    ctrl_chan #(.CNT_W(CNT_W)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .we          (chan_we[i]),
      .go_bit      (sw_wdata[GO]),
      .mode_bit    (sw_wdata[MODE]),
      .abort_bit   (sw_wdata[ABORT]),
      .ie_bit      (sw_wdata[IE]),
      .clr_bit     (sw_wdata[DONE]),
      .hw_inc      (hw_inc[i]),
      .hw_done     (hw_done[i]),
      .word        (chan_word[i]),
      .start_pulse (start_pulse[i]),
      .irq_req     (chan_irq[i])
    );

    assign ctrl_out[32*i +: 32] = chan_word[i];
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    sw_rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sw_addr == AW'(i)) sw_rdata = chan_word[i];
    end
  end

`ifdef CTRL_REG_BANK_IRQ_EN
  logic irq_q;

  // Interrupt is the registered OR of enabled done flags.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |chan_irq;
  end

  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^chan_irq;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_reg_bank.sv
// Directed bench for ctrl_reg_bank: default instance (N_CH=2, CNT_W=8) plus a
// CNT_W=4 instance for counter saturation.
module tb_ctrl_reg_bank;

`ifdef CTRL_REG_BANK_IRQ_EN
  localparam logic [31:0] IEB = 32'h8;
  localparam logic        IRQ_ON = 1'b1;
`else
  localparam logic [31:0] IEB = 32'h0;
  localparam logic        IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sw_we = 1'b0;
  logic [3:0]  sw_addr = '0;
  logic [31:0] sw_wdata = '0;
  logic [31:0] sw_rdata, sw_rdata2;
  logic [1:0]  hw_inc = '0, hw_done = '0;
  logic [1:0]  hw_inc2 = '0, hw_done2 = '0;
  logic [1:0]  start_pulse, start_pulse2;
  logic [63:0] ctrl_out, ctrl_out2;
  logic        irq, irq2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ctrl_reg_bank #(.N_CH(2), .CNT_W(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .sw_we(sw_we), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_rdata(sw_rdata), .hw_inc(hw_inc), .hw_done(hw_done),
    .start_pulse(start_pulse), .ctrl_out(ctrl_out), .irq(irq)
  );

  ctrl_reg_bank #(.N_CH(2), .CNT_W(4), .AW(4)) dut4 (
    .clk(clk), .rst(rst), .sw_we(sw_we), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_rdata(sw_rdata2), .hw_inc(hw_inc2), .hw_done(hw_done2),
    .start_pulse(start_pulse2), .ctrl_out(ctrl_out2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    sw_addr = addr;
    #1;
    chk(tag, {32'h0, sw_rdata}, {32'h0, exp});
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    sw_we    = 1'b1;
    sw_addr  = addr;
    sw_wdata = data;
    tick();
    sw_we    = 1'b0;
    sw_wdata = '0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_rd("rst_rd0", 4'd0, 32'h0);
    chk_rd("rst_rd1", 4'd1, 32'h0);
    chk("rst_ctrl_out", ctrl_out, 64'h0);
    chk("rst_irq", {63'h0, irq}, 64'h0);
    chk("rst_start", {62'h0, start_pulse}, 64'h0);

    // Start ch1 with go|mode|ie
    wr(4'd1, 32'h0000_000B);
    chk("ch1_start_pulse", {62'h0, start_pulse}, 64'h2);
    chk_rd("ch1_busy_word", 4'd1, 32'h13 | IEB);
    chk("ch1_ctrl_out", ctrl_out, {32'h13 | IEB, 32'h0});
    tick();
    chk("ch1_pulse_once", {62'h0, start_pulse}, 64'h0);

    hw_inc = 2'b10;
    tick(); tick(); tick();
    hw_inc = 2'b00;
    chk_rd("ch1_cnt3", 4'd1, 32'h313 | IEB);

    // ch0: start, count 2, then hw_done with a simultaneous abort
    wr(4'd0, 32'h0000_000B);
    chk("ch0_start_pulse", {62'h0, start_pulse}, 64'h1);
    hw_inc = 2'b01;
    tick(); tick();
    hw_inc = 2'b00;
    hw_done = 2'b01;
    wr(4'd0, 32'h0000_0004);
    hw_done = 2'b00;
    chk_rd("ch0_done_wins", 4'd0, 32'h222 | IEB);
    chk("ch0_irq_not_yet", {63'h0, irq}, 64'h0);
    tick();
    chk("ch0_irq_set", {63'h0, irq}, {63'h0, IRQ_ON});
    chk_rd("ch0_done_hold", 4'd0, 32'h222 | IEB);

    // W1C done; the same write also clears mode/ie since ch0 is not BUSY
    wr(4'd0, 32'h0000_0020);
    chk_rd("ch0_done_clr", 4'd0, 32'h200);
    tick();
    chk("ch0_irq_clr", {63'h0, irq}, 64'h0);
    chk_rd("ch1_untouched", 4'd1, 32'h313 | IEB);

    // go while BUSY ignored, mode/ie write ignored
    wr(4'd1, 32'h0000_0001);
    chk("ch1_go_busy_nopulse", {62'h0, start_pulse}, 64'h0);
    chk_rd("ch1_go_busy_word", 4'd1, 32'h313 | IEB);

    // Abort from BUSY keeps count and mode/ie
    wr(4'd1, 32'h0000_0004);
    chk_rd("ch1_abort", 4'd1, 32'h302 | IEB);

    // hw events outside BUSY ignored
    hw_inc = 2'b11;
    hw_done = 2'b11;
    tick();
    hw_inc = 2'b00;
    hw_done = 2'b00;
    tick();
    chk("idle_hw_ignored", ctrl_out, {32'h302 | IEB, 32'h200});

    // Unmapped address write/read
    wr(4'd2, 32'hFFFF_FFFF);
    chk("oob_no_change", ctrl_out, {32'h302 | IEB, 32'h200});
    chk("oob_no_pulse", {62'h0, start_pulse}, 64'h0);
    chk_rd("oob_rd2", 4'd2, 32'h0);
    chk_rd("oob_rd15", 4'd15, 32'h0);

    // Reset mid-BUSY, with a go write in the reset cycle
    wr(4'd0, 32'h0000_0001);
    hw_inc = 2'b01;
    repeat (5) tick();
    hw_inc = 2'b00;
    chk_rd("ch0_cnt5", 4'd0, 32'h511);
    rst = 1'b1;
    wr(4'd0, 32'h0000_0001);
    rst = 1'b0;
    chk("rst_mid_busy", ctrl_out, 64'h0);
    chk("rst_mid_nopulse", {62'h0, start_pulse}, 64'h0);
    hw_done = 2'b01;
    tick();
    hw_done = 2'b00;
    tick();
    chk("post_rst_hw_done", ctrl_out, 64'h0);
    chk("post_rst_irq", {63'h0, irq}, 64'h0);

    // Saturation on the CNT_W=4 instance
    wr(4'd0, 32'h0000_0001);
    chk("sat_start", {62'h0, start_pulse2}, 64'h1);
    hw_inc2 = 2'b01;
    repeat (20) tick();
    hw_inc2 = 2'b00;
    chk("sat_word", ctrl_out2, {32'h0, 32'h0000_0F11});
    sw_addr = 4'd0;
    #1;
    chk("sat_cnt_field", {60'h0, sw_rdata2[11:8]}, 64'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
